mat4add_arbiter: RTL
====================

// Module: mat4add_arbiter
// PURPOSE
//  Round-robin scheduler that shares one mat4add unit (4 x 64-bit lanes, 256-bit a/b/c, start/done) among NREQ requesters.
//  Accepts one request at a time, captures its operands, pulses start, waits for done, then returns c to the winner.
//  Sits between the SoC matrix clients and the single mat4add instance.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  TIMEOUT  64   max cycles in WAIT before abort (used only with MAT_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  req        in   NREQ       per-requester request level
//  req_a      in   NREQ*256   operand a per requester, slice i = [256*i +: 256]
//  req_b      in   NREQ*256   operand b per requester
//  req_ack    out  NREQ       one-cycle pulse: operands of requester i captured
//  rsp_valid  out  NREQ       result for requester i valid on rsp_c
//  rsp_ready  in   NREQ       requester i accepts result
//  rsp_c      out  256        shared result bus
//  mat_start  out  1          one-cycle start pulse to mat4add
//  mat_a      out  256        operand a to mat4add
//  mat_b      out  256        operand b to mat4add
//  mat_c      in   256        mat4add result, valid while mat_done=1
//  mat_done   in   1          mat4add completion
//  busy       out  1          high in every state except IDLE
//  err        out  1          sticky timeout flag (0 when MAT_ARB_TIMEOUT_EN undefined)
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=0, req_ack=0, rsp_valid=0, rsp_c=0, mat_start=0, mat_a=0, mat_b=0, busy=0, err=0.
//  - All outputs registered. FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE: if |req, grant the first set bit searching from ptr upward with wrap; latch grant id, mat_a/mat_b <= winner's operands. -> ISSUE.
//  - ISSUE (exactly 1 cycle): mat_start=1, req_ack[id]=1. -> WAIT.
//  - WAIT: mat_a/mat_b held stable; mat_done is sampled only here. On mat_done: rsp_c <= mat_c, rsp_valid[id]=1. -> RESP.
//  - RESP: hold rsp_valid[id] and rsp_c until rsp_ready[id]=1. On that edge, rsp_valid=0, ptr <= id+1 (mod NREQ). -> IDLE.
//  - Minimum latency: req seen at edge T; mat_start/req_ack in cycle T+1; mat_done at T+2 gives rsp_valid at T+3.
//  - Requesters hold req, req_a and req_b stable until req_ack, then deassert req or raise a new request.
//  - Request deasserted before grant: never granted; no error.
//  - Fairness: a continuously requesting client waits at most NREQ-1 other grants.
//  - Only one transaction is in flight. req is ignored outside IDLE; mat_done is ignored outside WAIT.
//  - rsp_ready asserted in the same cycle rsp_valid rises: the handshake completes on the next edge (valid is high at least 1 cycle).
//  - rst mid-transaction: immediate return to reset values, with no response to the pending requester. mat4add shares rst.
// CONFIGURATION
//  MAT_ARB_TIMEOUT_EN defined:
//   - WAIT counts cycles. If TIMEOUT cycles pass with no mat_done: err <= 1 (sticky until rst).
//   - rsp_c <= 256'hDEAD..DEAD, then RESP as normal.
//  MAT_ARB_TIMEOUT_EN undefined: no counter, WAIT indefinitely, err tied 0.
// STRUCTURE
//  - Package mia_mat_pkg: LANE_W=64, LANES=4, VEC_W=256, typedef logic [VEC_W-1:0] vec_t, arb_state_e enum {IDLE,ISSUE,WAIT,RESP}.
//  - Sub-module rr_pick: combinational round-robin picker (req, ptr -> onehot grant, id). FSM and datapath registers stay in top.
// TESTING
//  1 Single request: req[0]=1, a lanes={4,3,2,1}, b lanes={4,3,2,1}.
//    -> req_ack[0] 1 cycle after req; rsp_c lanes={8,6,4,2}; rsp_valid[0] until rsp_ready[0].
//  2 Contention: req=4'b1111 held, each requester re-requesting after ack.
//    -> grant order 0,1,2,3,0; each client's own operands land on mat_a/mat_b.
//  3 Backpressure: rsp_ready[2]=0 for 10 cycles.
//    -> rsp_valid[2]/rsp_c stable; req[1] raised meanwhile is not acked until RESP exits.
//  4 Spurious done: mat_done pulsed during IDLE and RESP.
//    -> no state change, rsp_c unchanged.
//  5 Reset in WAIT: rst=1 for 1 cycle.
//    -> all outputs 0, busy=0; next req[3] gets ack at 2nd cycle after rst falls.
//  6 MAT_ARB_TIMEOUT_EN, TIMEOUT=8, mat_done never asserted.
//    -> err=1 and rsp_valid[id]=1 with DEAD pattern 8 cycles after mat_start.

Source files
------------

// File: rtl/mia_mat_pkg.sv
// Shared types and constants for the mat4add round-robin arbiter.
package mia_mat_pkg;
  localparam int LANE_W = 64;
  localparam int LANES  = 4;
  localparam int VEC_W  = LANE_W * LANES;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Result returned to a requester whose operation was abandoned on timeout
  localparam vec_t DEAD_PAT = {(VEC_W / 16){16'hDEAD}};
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] id,
  output logic            vld
);
  always_comb begin
    int idx;
    gnt = '0;
    id  = '0;
    vld = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!vld && req[idx]) begin
        vld      = 1'b1;
        gnt[idx] = 1'b1;
        id       = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/mat4add_arbiter.sv
// Round-robin scheduler sharing one mat4add unit among NREQ requesters.
// Optional WAIT-state timeout with sticky err is enabled by defining MAT_ARB_TIMEOUT_EN.
module mat4add_arbiter
  import mia_mat_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*VEC_W-1:0] req_a,
  input  logic [NREQ*VEC_W-1:0] req_b,
  output logic [NREQ-1:0]     req_ack,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output vec_t                rsp_c,
  output logic                mat_start,
  output vec_t                mat_a,
  output vec_t                mat_b,
  input  vec_t                mat_c,
  input  logic                mat_done,
  output logic                busy,
  output logic                err
);
  localparam int ID_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_param_check
    $error("mat4add_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
  end

  arb_state_e      state, state_nxt;
  logic [ID_W-1:0] ptr, id, pick_id;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_vld;
  logic            tmo;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .id  (pick_id),
    .vld (pick_vld)
  );

`ifdef MAT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // cnt counts cycles since mat_start; it is cleared when a grant is made
  assign tmo = (state == WAIT) && !mat_done && (cnt == CNT_W'(TIMEOUT - 1));
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE) cnt <= '0;
      else if (state == ISSUE || (state == WAIT && !mat_done && !tmo)) cnt <= cnt + 1'b1;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mat_done || tmo) state_nxt = RESP;
      RESP:    if (rsp_ready[id]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      id        <= '0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_c     <= '0;
      mat_start <= 1'b0;
      mat_a     <= '0;
      mat_b     <= '0;
      busy      <= 1'b0;
    end else begin
      mat_start <= 1'b0;
      req_ack   <= '0;
      busy      <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          // Grant registers ack/start so they appear during the ISSUE cycle
          if (pick_vld) begin
            id        <= pick_id;
            mat_a     <= req_a[VEC_W*pick_id +: VEC_W];
            mat_b     <= req_b[VEC_W*pick_id +: VEC_W];
            mat_start <= 1'b1;
            req_ack   <= pick_gnt;
          end
        end
        WAIT: begin
          if (mat_done) begin
            rsp_c     <= mat_c;
            rsp_valid <= NREQ'(1) << id;
          end else if (tmo) begin
            rsp_c     <= DEAD_PAT;
            rsp_valid <= NREQ'(1) << id;
          end
        end
        RESP: begin
          if (rsp_ready[id]) begin
            rsp_valid <= '0;
            ptr       <= (id == ID_W'(NREQ - 1)) ? '0 : id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
